// File: rtl/sort4_frame_collector.sv
// sort4_frame_collector: gathers a serial stream of DW-bit elements into
// 4-element frames, flags whether each frame is non-decreasing, and hands
// frames downstream through a 2-entry FIFO with valid/ready.
module sort4_frame_collector #(
    parameter int DW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inp_valid,
    input  logic [DW-1:0]   inp,
    input  logic            inp_sof,
    input  logic            frame_ready,
    output logic            frame_valid,
    output logic [4*DW-1:0] frame_data,
    output logic            frame_sorted,
    output logic [7:0]      frame_count,
    output logic            overflow,
    output logic            misalign
);

    // Collection state: slots 0..2 are buffered; the element landing in
    // slot 3 comes straight from inp and completes the frame.
    logic [1:0]             cnt_q, cnt_d;
    logic [2:0][DW-1:0]     slot_q, slot_d;
    logic                   push, sof_err;
    logic [4*DW-1:0]        frame_new;
    logic                   sorted_new;

    // FIFO state: one-bit pointers over two entries, explicit occupancy.
    logic [1:0][4*DW-1:0]   mem_q, mem_d;
    logic [1:0]             srt_q, srt_d;
    logic                   rd_q, rd_d, wr_q, wr_d;
    logic [1:0]             occ_q, occ_d;
    logic                   pop, full, wr_en;
    logic [7:0]             count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   misalign_q, misalign_d;

    // Slot counter and element capture, with sof resynchronisation.
    always_comb begin
        cnt_d     = cnt_q;
        slot_d    = slot_q;
        push      = 1'b0;
        sof_err   = 1'b0;
        frame_new = {inp, slot_q[2], slot_q[1], slot_q[0]};
        if (inp_valid) begin
            if (inp_sof && cnt_q != 2'd0) begin
                // Drop the partial group and restart it with this element.
                slot_d[0] = inp;
                cnt_d     = 2'd1;
                sof_err   = 1'b1;
            end else begin
                case (cnt_q)
                    2'd0:    slot_d[0] = inp;
                    2'd1:    slot_d[1] = inp;
                    2'd2:    slot_d[2] = inp;
                    default: push      = 1'b1;
                endcase
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    // Unsigned non-decreasing check over the frame being completed.
    always_comb begin
        sorted_new = (slot_q[0] <= slot_q[1]) && (slot_q[1] <= slot_q[2]) &&
                     (slot_q[2] <= inp);
    end

    // FIFO control: pop/push may coincide at any occupancy; a push into a
    // full FIFO without a pop is dropped and recorded as overflow.
    always_comb begin
        full       = (occ_q == 2'd2);
        pop        = (occ_q != 2'd0) && frame_ready;
        wr_en      = push && (!full || pop);
        mem_d      = mem_q;
        srt_d      = srt_q;
        if (wr_en) begin
            mem_d[wr_q] = frame_new;
            srt_d[wr_q] = sorted_new;
        end
        rd_d       = rd_q ^ pop;
        wr_d       = wr_q ^ wr_en;
        case ({wr_en, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        count_d    = pop ? count_q + 8'd1 : count_q;
        overflow_d = overflow_q | (push && full && !pop);
        misalign_d = misalign_q | sof_err;
    end

    // State registers, all cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            slot_q     <= '0;
            mem_q      <= '0;
            srt_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            occ_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            mem_q      <= mem_d;
            srt_q      <= srt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            occ_q      <= occ_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            misalign_q <= misalign_d;
        end
    end

    // Present the FIFO head; zero when nothing is buffered.
    always_comb begin
        frame_valid  = (occ_q != 2'd0);
        frame_data   = frame_valid ? mem_q[rd_q] : '0;
        frame_sorted = frame_valid & srt_q[rd_q];
        frame_count  = count_q;
        overflow     = overflow_q;
        misalign     = misalign_q;
    end

endmodule

// File: tb/tb_sort4_frame_collector.sv
// Directed bench for sort4_frame_collector: inputs change on the falling
// edge, outputs are checked on the falling edge, away from the rising edge.
`timescale 1ns/1ps
module tb_sort4_frame_collector;

    localparam int DW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            inp_valid = 1'b0;
    logic [DW-1:0]   inp = '0;
    logic            inp_sof = 1'b0;
    logic            frame_ready = 1'b0;
    logic            frame_valid;
    logic [4*DW-1:0] frame_data;
    logic            frame_sorted;
    logic [7:0]      frame_count;
    logic            overflow;
    logic            misalign;

    int errors = 0;
    int checks = 0;

    sort4_frame_collector #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .inp_valid(inp_valid), .inp(inp),
        .inp_sof(inp_sof), .frame_ready(frame_ready),
        .frame_valid(frame_valid), .frame_data(frame_data),
        .frame_sorted(frame_sorted), .frame_count(frame_count),
        .overflow(overflow), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // One element across one rising edge; valid drops afterwards unless
    // the next call re-asserts it at the same instant.
    task automatic send(input logic [DW-1:0] e, input logic sof);
        inp_valid = 1'b1;
        inp       = e;
        inp_sof   = sof;
        @(negedge clk);
        inp_valid = 1'b0;
        inp_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        idle(2);
        checks++;
        if ({frame_valid, frame_data, frame_sorted, frame_count, overflow, misalign} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%b c=%0d o=%b m=%b, expected all 0",
                     frame_valid, frame_data, frame_sorted, frame_count, overflow, misalign);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_sorted;
        frame_ready = 1'b1;
        send(3'd1, 1'b1); send(3'd2, 1'b0); send(3'd5, 1'b0); send(3'd7, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== {3'd7, 3'd5, 3'd2, 3'd1} ||
            frame_sorted !== 1'b1 || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL sorted_frame: got v=%b d=%h s=%b c=%0d, expected v=1 d=%h s=1 c=0",
                     frame_valid, frame_data, frame_sorted, frame_count, {3'd7, 3'd5, 3'd2, 3'd1});
        end
        idle(1);
        checks++;
        if (frame_valid !== 1'b0 || frame_count !== 8'd1) begin
            errors++;
            $display("FAIL sorted_pop: got v=%b c=%0d, expected v=0 c=1", frame_valid, frame_count);
        end
    endtask

    task automatic test_unsorted;
        send(3'd6, 1'b0); send(3'd5, 1'b0); send(3'd4, 1'b0); send(3'd3, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== {3'd3, 3'd4, 3'd5, 3'd6} || frame_sorted !== 1'b0) begin
            errors++;
            $display("FAIL unsorted_frame: got v=%b d=%h s=%b, expected v=1 d=%h s=0",
                     frame_valid, frame_data, frame_sorted, {3'd3, 3'd4, 3'd5, 3'd6});
        end
        idle(1);
    endtask

    task automatic test_equal;
        send(3'd2, 1'b0); send(3'd2, 1'b0); send(3'd2, 1'b0); send(3'd2, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== {3'd2, 3'd2, 3'd2, 3'd2} || frame_sorted !== 1'b1) begin
            errors++;
            $display("FAIL equal_frame: got v=%b d=%h s=%b, expected v=1 d=492 s=1",
                     frame_valid, frame_data, frame_sorted);
        end
        idle(1);
        checks++;
        if (frame_count !== 8'd3) begin
            errors++;
            $display("FAIL equal_count: got %0d, expected 3", frame_count);
        end
    endtask

    task automatic test_overflow;
        frame_ready = 1'b0;
        send(3'd1, 1'b1); send(3'd2, 1'b0); send(3'd3, 1'b0); send(3'd4, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== {3'd4, 3'd3, 3'd2, 3'd1} || frame_sorted !== 1'b1) begin
            errors++;
            $display("FAIL ovf_head_a: got v=%b d=%h s=%b, expected v=1 d=%h s=1",
                     frame_valid, frame_data, frame_sorted, {3'd4, 3'd3, 3'd2, 3'd1});
        end
        send(3'd4, 1'b1); send(3'd3, 1'b0); send(3'd2, 1'b0); send(3'd1, 1'b0);
        checks++;
        if (frame_data !== {3'd4, 3'd3, 3'd2, 3'd1} || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_hold_b: got d=%h o=%b, expected d=%h o=0",
                     frame_data, overflow, {3'd4, 3'd3, 3'd2, 3'd1});
        end
        send(3'd0, 1'b1); send(3'd0, 1'b0); send(3'd0, 1'b0); send(3'd0, 1'b0);
        checks++;
        if (frame_data !== {3'd4, 3'd3, 3'd2, 3'd1} || overflow !== 1'b1 || frame_count !== 8'd3) begin
            errors++;
            $display("FAIL ovf_drop_c: got d=%h o=%b c=%0d, expected d=%h o=1 c=3",
                     frame_data, overflow, frame_count, {3'd4, 3'd3, 3'd2, 3'd1});
        end
        frame_ready = 1'b1;
        idle(1);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== {3'd1, 3'd2, 3'd3, 3'd4} ||
            frame_sorted !== 1'b0 || frame_count !== 8'd4) begin
            errors++;
            $display("FAIL ovf_deliver_b: got v=%b d=%h s=%b c=%0d, expected v=1 d=%h s=0 c=4",
                     frame_valid, frame_data, frame_sorted, frame_count, {3'd1, 3'd2, 3'd3, 3'd4});
        end
        idle(1);
        checks++;
        if (frame_valid !== 1'b0 || frame_count !== 8'd5 || overflow !== 1'b1 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drained: got v=%b c=%0d o=%b m=%b, expected v=0 c=5 o=1 m=0",
                     frame_valid, frame_count, overflow, misalign);
        end
    endtask

    task automatic test_misalign;
        send(3'd1, 1'b0); send(3'd2, 1'b0); send(3'd0, 1'b1);
        checks++;
        if (frame_valid !== 1'b0 || misalign !== 1'b1) begin
            errors++;
            $display("FAIL misalign_flag: got v=%b m=%b, expected v=0 m=1", frame_valid, misalign);
        end
        send(3'd3, 1'b0); send(3'd4, 1'b0); send(3'd6, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== {3'd6, 3'd4, 3'd3, 3'd0} || frame_sorted !== 1'b1) begin
            errors++;
            $display("FAIL misalign_frame: got v=%b d=%h s=%b, expected v=1 d=%h s=1",
                     frame_valid, frame_data, frame_sorted, {3'd6, 3'd4, 3'd3, 3'd0});
        end
        idle(2);
        checks++;
        if (frame_valid !== 1'b0 || frame_count !== 8'd6) begin
            errors++;
            $display("FAIL misalign_count: got v=%b c=%0d, expected v=0 c=6", frame_valid, frame_count);
        end
    endtask

    task automatic test_async_reset;
        frame_ready = 1'b0;
        send(3'd1, 1'b1); send(3'd1, 1'b0); send(3'd1, 1'b0); send(3'd1, 1'b0);
        send(3'd5, 1'b1); send(3'd6, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({frame_valid, frame_data, frame_sorted, frame_count, overflow, misalign} !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h s=%b c=%0d o=%b m=%b, expected all 0",
                     frame_valid, frame_data, frame_sorted, frame_count, overflow, misalign);
        end
        @(negedge clk);
        rst = 1'b0;
        frame_ready = 1'b1;
        send(3'd3, 1'b0); send(3'd2, 1'b0); send(3'd1, 1'b0); send(3'd0, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== {3'd0, 3'd1, 3'd2, 3'd3} || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_frame: got v=%b d=%h c=%0d, expected v=1 d=%h c=0",
                     frame_valid, frame_data, frame_count, {3'd0, 3'd1, 3'd2, 3'd3});
        end
        idle(3);
        checks++;
        if (frame_valid !== 1'b0 || frame_count !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_single: got v=%b c=%0d, expected v=0 c=1", frame_valid, frame_count);
        end
    endtask

    // Back-to-back frames with ready held high until the count wraps.
    task automatic test_back_to_back_wrap;
        logic [DW-1:0] e;
        for (int i = 0; i < 254; i++) begin
            e = DW'(i);
            send(e, 1'b0); send(e, 1'b0); send(e, 1'b0); send(e, 1'b0);
        end
        idle(1);
        checks++;
        if (frame_valid !== 1'b0 || frame_count !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: got v=%b c=%0d, expected v=0 c=255", frame_valid, frame_count);
        end
        send(3'd7, 1'b1); send(3'd0, 1'b0); send(3'd7, 1'b0); send(3'd0, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || frame_sorted !== 1'b0 || frame_count !== 8'd255) begin
            errors++;
            $display("FAIL wrap_last: got v=%b s=%b c=%0d, expected v=1 s=0 c=255",
                     frame_valid, frame_sorted, frame_count);
        end
        idle(1);
        checks++;
        if (frame_valid !== 1'b0 || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_zero: got v=%b c=%0d, expected v=0 c=0", frame_valid, frame_count);
        end
    endtask

    initial begin
        test_reset;
        test_sorted;
        test_unsorted;
        test_equal;
        test_overflow;
        test_misalign;
        test_async_reset;
        test_back_to_back_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
